// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: drives a variable-latency data memory through a
// req/ready handshake, stalls the pipeline while busy and owns the MEM/WB register.
module mem_stage_ctrl #(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_mem_read,
    input  logic             i_mem_write,
    input  logic [1:0]       i_mem_to_reg,
    input  logic             i_reg_write,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic [WIDTH-1:0] i_write_data,
    input  logic [4:0]       i_rd,
    input  logic             i_dmem_ready,
    input  logic [WIDTH-1:0] i_dmem_rdata,
    output logic             o_dmem_req,
    output logic             o_dmem_we,
    output logic [WIDTH-1:0] o_dmem_addr,
    output logic [WIDTH-1:0] o_dmem_wdata,
    output logic             o_stall,
    output logic             o_mem_err,
    output logic             o_wb_reg_write,
    output logic [1:0]       o_wb_mem_to_reg,
    output logic [WIDTH-1:0] o_wb_read_data,
    output logic [WIDTH-1:0] o_wb_alu_result,
    output logic [4:0]       o_wb_rd
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_WAIT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic             r_dmem_req;
    logic             r_dmem_we;
    logic [WIDTH-1:0] r_dmem_addr;
    logic [WIDTH-1:0] r_dmem_wdata;
    logic             r_mem_err;
    logic             r_wb_reg_write;
    logic [1:0]       r_wb_mem_to_reg;
    logic [WIDTH-1:0] r_wb_read_data;
    logic [WIDTH-1:0] r_wb_alu_result;
    logic [4:0]       r_wb_rd;

    logic             w_mem_op;
    logic             w_stall;
    logic             w_start;
    logic             w_wb_load;
    logic             w_timeout;
    logic             w_wb_rw;
    logic [WIDTH-1:0] w_wb_rdata;

    // a simultaneous read and write is treated as a write via r_dmem_we
    assign w_mem_op = i_mem_read | i_mem_write;

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_dmem_req      <= 1'b0;
            r_dmem_we       <= 1'b0;
            r_dmem_addr     <= '0;
            r_dmem_wdata    <= '0;
            r_mem_err       <= 1'b0;
            r_wb_reg_write  <= 1'b0;
            r_wb_mem_to_reg <= 2'b00;
            r_wb_read_data  <= '0;
            r_wb_alu_result <= '0;
            r_wb_rd         <= 5'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_mem_err <= w_timeout;
            if (w_start) begin
                r_cnt        <= '0;
                r_dmem_req   <= 1'b1;
                r_dmem_we    <= i_mem_write;
                r_dmem_addr  <= i_alu_result;
                r_dmem_wdata <= i_write_data;
            end else if ((r_state == ST_BUSY) && w_stall) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt      <= '0;
                r_dmem_req <= 1'b0;
            end
            if (w_wb_load) begin
                r_wb_reg_write  <= w_wb_rw;
                r_wb_mem_to_reg <= i_mem_to_reg;
                r_wb_read_data  <= w_wb_rdata;
                r_wb_alu_result <= i_alu_result;
                r_wb_rd         <= i_rd;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_mem_op) begin
                    w_state_nxt = ST_BUSY;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (i_dmem_ready || (r_cnt == LAST_CNT)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Stall, access launch and MEM/WB load decisions
    always_comb begin
        w_stall    = 1'b0;
        w_start    = 1'b0;
        w_wb_load  = 1'b0;
        w_timeout  = 1'b0;
        w_wb_rw    = i_reg_write;
        w_wb_rdata = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_mem_op) begin
                    w_stall = 1'b1;
                    w_start = 1'b1;
                end else begin
                    w_wb_load = 1'b1;
                end
            end
            ST_BUSY: begin
                if (i_dmem_ready) begin
                    w_wb_load  = 1'b1;
                    w_wb_rdata = r_dmem_we ? '0 : i_dmem_rdata;
                end else if (r_cnt == LAST_CNT) begin
                    // abandoned access must not write the register file
                    w_wb_load = 1'b1;
                    w_timeout = 1'b1;
                    w_wb_rw   = 1'b0;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: begin
                w_stall = 1'b0;
            end
        endcase
    end

    assign o_stall         = w_stall;
    assign o_dmem_req      = r_dmem_req;
    assign o_dmem_we       = r_dmem_we;
    assign o_dmem_addr     = r_dmem_addr;
    assign o_dmem_wdata    = r_dmem_wdata;
    assign o_mem_err       = r_mem_err;
    assign o_wb_reg_write  = r_wb_reg_write;
    assign o_wb_mem_to_reg = r_wb_mem_to_reg;
    assign o_wb_read_data  = r_wb_read_data;
    assign o_wb_alu_result = r_wb_alu_result;
    assign o_wb_rd         = r_wb_rd;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: instruction-level model of stall length, request
// window and MEM/WB contents, checked every cycle, plus directed literal checks.
module tb_mem_stage_ctrl;
    localparam int W  = 32;
    localparam int MW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, mem_read, mem_write, reg_write, dmem_ready;
    logic [1:0] mem_to_reg;
    logic [W-1:0] alu_result, write_data, dmem_rdata;
    logic [4:0] rd;
    logic dmem_req, dmem_we, stall, mem_err, wb_reg_write;
    logic [W-1:0] dmem_addr, dmem_wdata, wb_read_data, wb_alu_result;
    logic [1:0] wb_mem_to_reg;
    logic [4:0] wb_rd;

    mem_stage_ctrl #(.WIDTH(W), .MAX_WAIT(MW)) dut (
        .i_clk(clk), .i_rst(rst), .i_mem_read(mem_read), .i_mem_write(mem_write),
        .i_mem_to_reg(mem_to_reg), .i_reg_write(reg_write), .i_alu_result(alu_result),
        .i_write_data(write_data), .i_rd(rd), .i_dmem_ready(dmem_ready),
        .i_dmem_rdata(dmem_rdata), .o_dmem_req(dmem_req), .o_dmem_we(dmem_we),
        .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata), .o_stall(stall),
        .o_mem_err(mem_err), .o_wb_reg_write(wb_reg_write),
        .o_wb_mem_to_reg(wb_mem_to_reg), .o_wb_read_data(wb_read_data),
        .o_wb_alu_result(wb_alu_result), .o_wb_rd(wb_rd)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int stall_total = 0;
    logic chk_en = 1'b0;

    // expectations for the current cycle
    logic exp_stall, exp_req, exp_we, exp_err;
    logic [W-1:0] exp_addr, exp_wdata;
    // MEM/WB image now (m_) and after the coming edge (n_)
    logic m_rw, n_rw, m_err, n_err;
    logic [1:0] m_m2r, n_m2r;
    logic [W-1:0] m_alu, n_alu, m_rdata, n_rdata;
    logic [4:0] m_rd, n_rd;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", {31'd0, stall}, {31'd0, exp_stall});
            check("dmem_req", {31'd0, dmem_req}, {31'd0, exp_req});
            check("mem_err", {31'd0, mem_err}, {31'd0, exp_err});
            check("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, m_rw});
            check("wb_mem_to_reg", {30'd0, wb_mem_to_reg}, {30'd0, m_m2r});
            check("wb_read_data", wb_read_data, m_rdata);
            check("wb_alu_result", wb_alu_result, m_alu);
            check("wb_rd", {27'd0, wb_rd}, {27'd0, m_rd});
            if (exp_req) begin
                check("dmem_we", {31'd0, dmem_we}, {31'd0, exp_we});
                check("dmem_addr", dmem_addr, exp_addr);
                check("dmem_wdata", dmem_wdata, exp_wdata);
            end
            if (stall) stall_total++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        m_rw = n_rw; m_m2r = n_m2r; m_alu = n_alu; m_rd = n_rd;
        m_rdata = n_rdata; m_err = n_err;
    endtask

    task automatic zero_next();
        n_rw = 1'b0; n_m2r = 2'b00; n_alu = '0; n_rd = 5'd0; n_rdata = '0; n_err = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 2'b00; reg_write = 1'b0;
        alu_result = '0; write_data = '0; rd = 5'd0; dmem_ready = 1'b0; dmem_rdata = '0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_err = 1'b0;
        exp_addr = '0; exp_wdata = '0;
        zero_next();
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // One instruction in MEM; lat = request cycle carrying ready (> MW: never ready).
    task automatic run_instr(input logic rd_op, input logic wr_op, input logic [1:0] m2r,
                             input logic rw, input logic [W-1:0] alu, input logic [W-1:0] wd,
                             input logic [4:0] rdn, input int lat, input logic [W-1:0] rdat,
                             input int rst_at, input logic junk);
        logic mem, tmo;
        int scyc, ncyc;
        mem  = rd_op | wr_op;
        tmo  = mem && (lat > MW);
        scyc = mem ? ((lat < MW) ? lat : MW) : 0;
        ncyc = scyc + 1;
        for (int c = 0; c < ncyc; c++) begin
            mem_read = rd_op; mem_write = wr_op; mem_to_reg = m2r; reg_write = rw;
            alu_result = alu; write_data = wd; rd = rdn;
            if (mem && (c > 0) && (c == lat)) begin
                dmem_ready = 1'b1; dmem_rdata = rdat;
            end else begin
                dmem_ready = (c == 0) ? junk : 1'b0; dmem_rdata = $urandom;
            end
            exp_stall = (c < scyc);
            exp_req = mem && (c > 0);
            exp_we = wr_op; exp_addr = alu; exp_wdata = wd; exp_err = m_err;
            n_rw = m_rw; n_m2r = m_m2r; n_alu = m_alu; n_rd = m_rd; n_rdata = m_rdata;
            n_err = 1'b0;
            if (c == ncyc - 1) begin
                n_rw = tmo ? 1'b0 : rw; n_m2r = m2r; n_alu = alu; n_rd = rdn;
                n_rdata = (mem && !wr_op && !tmo) ? rdat : '0;
                n_err = tmo;
            end
            if (c == rst_at) begin
                rst = 1'b1;
                zero_next();
                step();
                rst = 1'b0;
                return;
            end
            step();
        end
    endtask

    initial begin
        int s0, lat, ra, op;
        m_rw = 1'b0; m_m2r = 2'b00; m_alu = '0; m_rd = 5'd0; m_rdata = '0; m_err = 1'b0;
        do_reset();
        check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        check("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        check("rst_dmem_wdata", dmem_wdata, 32'd0);
        check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);

        s0 = stall_total;
        run_instr(1'b0, 1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 5'd7, 1, 32'h0, -1, 1'b0);
        check("alu_stall_cycles", s0 ^ stall_total, 32'd0);
        check("alu_wb_rd", {27'd0, wb_rd}, 32'd7);
        check("alu_wb_alu", wb_alu_result, 32'h10);
        check("alu_wb_rdata", wb_read_data, 32'h0);

        s0 = stall_total;
        run_instr(1'b1, 1'b0, 2'd1, 1'b1, 32'h40, 32'h0, 5'd5, 1, 32'hDEADBEEF, -1, 1'b0);
        check("load_stall_cycles", stall_total - s0, 32'd1);
        check("load_wb_rdata", wb_read_data, 32'hDEADBEEF);
        check("load_req_drop", {31'd0, dmem_req}, 32'd0);

        s0 = stall_total;
        run_instr(1'b0, 1'b1, 2'd0, 1'b0, 32'h8, 32'h1234, 5'd3, 3, 32'hFFFF, -1, 1'b0);
        check("store_stall_cycles", stall_total - s0, 32'd3);
        check("store_wb_rdata", wb_read_data, 32'h0);

        s0 = stall_total;
        run_instr(1'b1, 1'b0, 2'd1, 1'b1, 32'h44, 32'h0, 5'd9, MW + 1, 32'h55, -1, 1'b0);
        check("tmo_stall_cycles", stall_total - s0, 32'd4);
        check("tmo_mem_err", {31'd0, mem_err}, 32'd1);
        check("tmo_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
        run_instr(1'b0, 1'b0, 2'd2, 1'b1, 32'h1, 32'h0, 5'd1, 1, 32'h0, -1, 1'b1);
        check("tmo_err_one_cycle", {31'd0, mem_err}, 32'd0);

        run_instr(1'b1, 1'b0, 2'd1, 1'b1, 32'h100, 32'h0, 5'd10, 2, 32'hA5A5A5A5, -1, 1'b1);
        run_instr(1'b1, 1'b0, 2'd1, 1'b1, 32'h104, 32'h0, 5'd11, 2, 32'h5A5A5A5A, -1, 1'b0);
        check("b2b_wb_rdata", wb_read_data, 32'h5A5A5A5A);
        run_instr(1'b1, 1'b1, 2'd0, 1'b1, 32'h200, 32'hCAFE, 5'd12, 2, 32'h77, -1, 1'b0);
        check("conflict_wb_rdata", wb_read_data, 32'h0);

        run_instr(1'b1, 1'b0, 2'd1, 1'b1, 32'h300, 32'h0, 5'd13, MW + 1, 32'h0, 2, 1'b0);
        check("midrst_dmem_req", {31'd0, dmem_req}, 32'd0);
        check("midrst_wb_rd", {27'd0, wb_rd}, 32'd0);
        check("midrst_wb_alu", wb_alu_result, 32'h0);
        run_instr(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 1, 32'h0, -1, 1'b1);
        check("midrst_late_ready", {31'd0, dmem_req}, 32'd0);

        for (int i = 0; i < 400; i++) begin
            op  = $urandom_range(0, 3);
            lat = $urandom_range(1, MW + 2);
            ra  = -1;
            if ((op != 0) && ($urandom_range(0, 19) == 0))
                ra = $urandom_range(1, (lat < MW) ? lat : MW);
            run_instr(op[0], op[1], 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      $urandom, $urandom, 5'($urandom_range(0, 31)), lat, $urandom, ra,
                      1'($urandom_range(0, 1)));
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller for the pipelined processor. It consumes the control and data fields held in the EX/MEM pipeline register (`mem_read`, `mem_write`, `mem_to_reg`, `reg_write`, ALU result, store data, destination register) and drives a data memory with variable latency through a request/ready handshake. It stalls the pipeline until each access completes and registers the MEM/WB control and data fields for write-back.

## Interface
- `WIDTH`, 32: data and address width.
- `MAX_WAIT`, 15: maximum number of BUSY cycles without `dmem_ready` before the access is abandoned (1..255).
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_read`  in  1  load in the MEM stage.
- `mem_write`  in  1  store in the MEM stage.
- `mem_to_reg`  in  2  write-back source select, passed through to the MEM/WB register.
- `reg_write`  in  1  register-file write enable, passed through.
- `alu_result`  in  WIDTH  memory address, or the ALU value for write-back.
- `write_data`  in  WIDTH  store data.
- `rd`  in  5  destination register.
- `dmem_ready`  in  1  memory completion strobe; valid only while `dmem_req` is 1.
- `dmem_rdata`  in  WIDTH  load data; valid when `dmem_ready` is 1.
- `dmem_req`  out  1  access request; registered.
- `dmem_we`  out  1  1 for a store, 0 for a load; registered.
- `dmem_addr`  out  WIDTH  access address; registered.
- `dmem_wdata`  out  WIDTH  store data; registered.
- `stall`  out  1  combinational; holds IF, ID, EX and EX/MEM.
- `mem_err`  out  1  registered one-cycle pulse on timeout.
- `wb_reg_write`, `wb_mem_to_reg`[2], `wb_read_data`[WIDTH], `wb_alu_result`[WIDTH], `wb_rd`[5]  out  the MEM/WB register.

## Operation
- Two states: IDLE and BUSY. A wait counter `cnt` of width clog2(MAX_WAIT+1) bits counts BUSY cycles.
- **IDLE, no memory operation** (`mem_read|mem_write` = 0):
  - `stall` = 0.
  - On the clock edge, the MEM/WB register loads the inputs and `wb_read_data` loads 0.
- **IDLE, memory operation present:**
  - `stall` = 1.
  - On the clock edge: go to BUSY; set `dmem_req` = 1; `dmem_we` = `mem_write`; `dmem_addr` = `alu_result`; `dmem_wdata` = `write_data`; `cnt` = 0. The MEM/WB register holds its value.
  - If `mem_read` and `mem_write` are both 1, the access is a write.
- **BUSY:**
  - `dmem_req`, `dmem_we`, `dmem_addr` and `dmem_wdata` stay stable until the access ends.
  - EX/MEM is held by `stall`, so the inputs remain valid.
- **BUSY with `dmem_ready` = 1:**
  - `stall` = 0.
  - On the edge: go to IDLE and set `dmem_req` = 0. The MEM/WB register loads the inputs.
  - `wb_read_data` = `dmem_rdata` for a load, 0 for a store.
- **BUSY with `dmem_ready` = 0 and `cnt` = MAX_WAIT−1 (timeout):**
  - `stall` = 0.
  - On the edge: go to IDLE, set `dmem_req` = 0, set `mem_err` = 1 for one cycle. The MEM/WB register loads the inputs but with `wb_reg_write` forced to 0 and `wb_read_data` = 0.
- **BUSY otherwise:** `stall` = 1; `cnt` increments.
- `dmem_ready` is ignored in IDLE.
- `mem_err` is 0 in every cycle other than the one following a timeout edge.

## Timing
- Reset (sampled at an edge):
  - State becomes IDLE and `cnt` = 0.
  - `dmem_req`, `dmem_we` and `mem_err` = 0.
  - `dmem_addr`, `dmem_wdata`, all `wb_*` outputs = 0.
  - `stall` = 0 from the cycle after reset.
- Reset while BUSY abandons the access: `dmem_req` is 0 in the following cycle and no MEM/WB update occurs.
- A non-memory instruction spends 1 cycle in MEM.
- A memory instruction spends N+1 cycles in MEM, where N is the number of cycles from `dmem_req` rising to `dmem_ready` (N ≥ 1).
- `stall` is high for exactly N cycles.
- Back-to-back memory operations: `dmem_req` drops for at least 1 cycle (the IDLE cycle) between accesses.
- A timeout keeps `stall` high for MAX_WAIT cycles in total (1 in IDLE plus MAX_WAIT−1 in BUSY).

## Test plan
- **Reset and ALU pass-through:** reset, then present `reg_write`=1, `rd`=7, `alu_result`=0x10, no memory op → `stall` stays 0; the next cycle shows `wb_rd`=7, `wb_alu_result`=0x10, `wb_read_data`=0, `dmem_req`=0.
- **Load, 1-cycle memory:** `mem_read`=1, `alu_result`=0x40; `dmem_ready`=1 with `dmem_rdata`=0xDEADBEEF in the first cycle `dmem_req`=1 → `stall` high 1 cycle; `dmem_addr`=0x40, `dmem_we`=0; then `wb_read_data`=0xDEADBEEF and `dmem_req`=0.
- **Store, 3-cycle memory:** `mem_write`=1, `write_data`=0x1234, `alu_result`=0x8; ready after 3 request cycles → `stall` high 3 cycles; `dmem_wdata`=0x1234 stable throughout; `wb_read_data`=0.
- **Timeout:** MAX_WAIT=4, load with `dmem_ready` never asserted → `stall` high 4 cycles; `mem_err` pulses 1 cycle; `wb_reg_write`=0.
- **Back-to-back and conflict:** two consecutive loads → `dmem_req` shows a 1-cycle gap. `mem_read`=`mem_write`=1 → `dmem_we`=1. Ready pulsed while IDLE → no effect.
- **Reset mid-access:** assert `rst` in the second BUSY cycle → `dmem_req`=0 and all outputs 0 the next cycle; a later `dmem_ready` is ignored.
